// File: rtl/fft_frame_collector.sv
// Receive-side frame collector for the FFT_IFFT output stream: double-buffered capture with valid/ready readout.
// Optional build macro FFT_COLLECT_BITREV_EN stores samples at bit-reversed addresses (natural bin order from ORDERING=0 cores).
module fft_frame_collector #(
   parameter int TOTAL_STEP = 6,
   parameter int DATA_WIDTH = 16
) (
   input  logic                         iclk,
   input  logic                         rstn,
   input  logic                         iclr,
   input  logic                         ien,
   input  logic signed [DATA_WIDTH-1:0] iReal,
   input  logic signed [DATA_WIDTH-1:0] iImag,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic signed [DATA_WIDTH-1:0] m_real,
   output logic signed [DATA_WIDTH-1:0] m_imag,
   output logic [TOTAL_STEP-1:0]        m_index,
   output logic                         m_last,
   output logic                         ovf,
   output logic [7:0]                   drop_cnt
);

   localparam int FFT_MAX = 1 << TOTAL_STEP;
   localparam int WORD_W  = 2 * DATA_WIDTH;
   localparam logic [TOTAL_STEP-1:0] LAST_IDX = {TOTAL_STEP{1'b1}};

   typedef enum logic [1:0] { WR_WAIT, WR_FILL, WR_DROP } wrState_t;
   typedef enum logic       { RD_IDLE, RD_SEND } rdState_t;

   logic [WORD_W-1:0]     r_mem [2][FFT_MAX];
   logic [1:0]            r_full;
   wrState_t              r_wrState;
   logic [TOTAL_STEP-1:0] r_wrCnt;
   logic                  r_wrBank;
   logic                  r_ovf;
   logic [7:0]            r_dropCnt;

   rdState_t              r_rdState;
   logic                  r_rdBank;
   logic                  r_mValid;
   logic [DATA_WIDTH-1:0] r_mReal;
   logic [DATA_WIDTH-1:0] r_mImag;
   logic [TOTAL_STEP-1:0] r_mIndex;
   logic                  r_mLast;

   wrState_t              w_wrStateNext;
   logic [TOTAL_STEP-1:0] w_wrCntNext;
   logic                  w_wrBankNext;
   logic                  w_wrEn;
   logic                  w_drop;
   logic [1:0]            w_setFull;
   logic [1:0]            w_clrFull;
   logic [1:0]            w_fullAfterRd;
   logic [TOTAL_STEP-1:0] w_wrAddr;

   rdState_t              w_rdStateNext;
   logic                  w_rdBankNext;
   logic                  w_load;
   logic                  w_loadBank;
   logic [TOTAL_STEP-1:0] w_loadIdx;
   logic                  w_validNext;
   logic [WORD_W-1:0]     w_rdWord;

`ifdef FFT_COLLECT_BITREV_EN
   function automatic logic [TOTAL_STEP-1:0] bitRev(input logic [TOTAL_STEP-1:0] v);
      logic [TOTAL_STEP-1:0] r;
      for (int i = 0; i < TOTAL_STEP; i++) begin
         r[i] = v[TOTAL_STEP-1-i];
      end
      return r;
   endfunction

   assign w_wrAddr = bitRev(r_wrCnt);
`else
   assign w_wrAddr = r_wrCnt;
`endif

   // Read side: the output register holds one sample; the last sample's load frees its bank.
   always_comb begin
      w_rdStateNext = r_rdState;
      w_rdBankNext  = r_rdBank;
      w_load        = 1'b0;
      w_loadBank    = r_rdBank;
      w_loadIdx     = '0;
      w_validNext   = r_mValid;
      case (r_rdState)
         RD_IDLE: begin
            if (r_full[r_rdBank]) begin
               w_load        = 1'b1;
               w_validNext   = 1'b1;
               w_rdStateNext = RD_SEND;
            end
         end
         RD_SEND: begin
            if (r_mValid && m_ready) begin
               if (r_mLast) begin
                  w_rdBankNext = ~r_rdBank;
                  w_loadBank   = ~r_rdBank;
                  if (r_full[~r_rdBank]) begin
                     w_load = 1'b1;
                  end else begin
                     w_validNext   = 1'b0;
                     w_rdStateNext = RD_IDLE;
                  end
               end else begin
                  w_load    = 1'b1;
                  w_loadIdx = r_mIndex + 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   assign w_rdWord      = r_mem[w_loadBank][w_loadIdx];
   assign w_clrFull     = (w_load && (w_loadIdx == LAST_IDX)) ? (2'b01 << w_loadBank) : 2'b00;
   assign w_fullAfterRd = r_full & ~w_clrFull;

   // Write side: a frame either claims wr_bank at its first sample or is discarded whole.
   always_comb begin
      w_wrStateNext = r_wrState;
      w_wrCntNext   = r_wrCnt;
      w_wrBankNext  = r_wrBank;
      w_wrEn        = 1'b0;
      w_drop        = 1'b0;
      w_setFull     = 2'b00;
      if (ien) begin
         case (r_wrState)
            WR_WAIT: begin
               w_wrCntNext = r_wrCnt + 1'b1;
               if (w_fullAfterRd[r_wrBank]) begin
                  w_drop        = 1'b1;
                  w_wrStateNext = WR_DROP;
               end else begin
                  w_wrEn        = 1'b1;
                  w_wrStateNext = WR_FILL;
               end
            end
            WR_FILL: begin
               w_wrEn = 1'b1;
               if (r_wrCnt == LAST_IDX) begin
                  w_setFull     = 2'b01 << r_wrBank;
                  w_wrBankNext  = ~r_wrBank;
                  w_wrCntNext   = '0;
                  w_wrStateNext = WR_WAIT;
               end else begin
                  w_wrCntNext = r_wrCnt + 1'b1;
               end
            end
            WR_DROP: begin
               if (r_wrCnt == LAST_IDX) begin
                  w_wrCntNext   = '0;
                  w_wrStateNext = WR_WAIT;
               end else begin
                  w_wrCntNext = r_wrCnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge iclk) begin
      if (w_wrEn) begin
         r_mem[r_wrBank][w_wrAddr] <= {iReal, iImag};
      end
   end

   always_ff @(posedge iclk or negedge rstn) begin
      if (!rstn) begin
         r_wrState <= WR_WAIT;
         r_wrCnt   <= '0;
         r_wrBank  <= 1'b0;
         r_full    <= 2'b00;
         r_ovf     <= 1'b0;
         r_dropCnt <= '0;
      end else if (iclr) begin
         r_wrState <= WR_WAIT;
         r_wrCnt   <= '0;
         r_wrBank  <= 1'b0;
         r_full    <= 2'b00;
         r_ovf     <= 1'b0;
         r_dropCnt <= '0;
      end else begin
         r_wrState <= w_wrStateNext;
         r_wrCnt   <= w_wrCntNext;
         r_wrBank  <= w_wrBankNext;
         r_full    <= w_fullAfterRd | w_setFull;
         if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_dropCnt != 8'hFF) begin
               r_dropCnt <= r_dropCnt + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge iclk or negedge rstn) begin
      if (!rstn) begin
         r_rdState <= RD_IDLE;
         r_rdBank  <= 1'b0;
         r_mValid  <= 1'b0;
         r_mReal   <= '0;
         r_mImag   <= '0;
         r_mIndex  <= '0;
         r_mLast   <= 1'b0;
      end else if (iclr) begin
         r_rdState <= RD_IDLE;
         r_rdBank  <= 1'b0;
         r_mValid  <= 1'b0;
         r_mReal   <= '0;
         r_mImag   <= '0;
         r_mIndex  <= '0;
         r_mLast   <= 1'b0;
      end else begin
         r_rdState <= w_rdStateNext;
         r_rdBank  <= w_rdBankNext;
         r_mValid  <= w_validNext;
         if (w_load) begin
            r_mReal  <= w_rdWord[WORD_W-1:DATA_WIDTH];
            r_mImag  <= w_rdWord[DATA_WIDTH-1:0];
            r_mIndex <= w_loadIdx;
            r_mLast  <= (w_loadIdx == LAST_IDX);
         end
      end
   end

   assign m_valid  = r_mValid;
   assign m_real   = r_mReal;
   assign m_imag   = r_mImag;
   assign m_index  = r_mIndex;
   assign m_last   = r_mLast;
   assign ovf      = r_ovf;
   assign drop_cnt = r_dropCnt;

endmodule

// File: tb/tb_fft_frame_collector.sv
// Scoreboard bench for fft_frame_collector: frames are modelled as arrays, expected outputs queued per frame.
`timescale 1ns/1ps
module tb_fft_frame_collector;

   localparam int TOTAL_STEP = 6;
   localparam int DATA_WIDTH = 16;
   localparam int FFT_MAX    = 1 << TOTAL_STEP;

   logic                         iclk = 1'b0;
   logic                         rstn = 1'b0;
   logic                         iclr = 1'b0;
   logic                         ien  = 1'b0;
   logic signed [DATA_WIDTH-1:0] iReal = '0;
   logic signed [DATA_WIDTH-1:0] iImag = '0;
   logic                         m_ready = 1'b0;
   logic                         m_valid;
   logic signed [DATA_WIDTH-1:0] m_real;
   logic signed [DATA_WIDTH-1:0] m_imag;
   logic [TOTAL_STEP-1:0]        m_index;
   logic                         m_last;
   logic                         ovf;
   logic [7:0]                   drop_cnt;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] re;
      logic [DATA_WIDTH-1:0] im;
      logic [TOTAL_STEP-1:0] idx;
      logic                  last;
   } outSample_t;

   outSample_t expQ[$];
   int testsRun     = 0;
   int testsFailed  = 0;
   int expDrops     = 0;
   int expOvf       = 0;
   int framesPushed = 0;
   int framesDone   = 0;
   int readyMode    = 0;
   int bubbleArm    = 0;
   int bubbleTarget = 0;
   int hsCount      = 0;
   int bubbles      = 0;

   fft_frame_collector #(
      .TOTAL_STEP(TOTAL_STEP),
      .DATA_WIDTH(DATA_WIDTH)
   ) dut (
      .iclk    (iclk),
      .rstn    (rstn),
      .iclr    (iclr),
      .ien     (ien),
      .iReal   (iReal),
      .iImag   (iImag),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_real  (m_real),
      .m_imag  (m_imag),
      .m_index (m_index),
      .m_last  (m_last),
      .ovf     (ovf),
      .drop_cnt(drop_cnt)
   );

   always #5 iclk = ~iclk;

   // Which arrival-order sample lands at output position i.
   function automatic int srcOf(input int i);
`ifdef FFT_COLLECT_BITREV_EN
      int r = 0;
      for (int b = 0; b < TOTAL_STEP; b++) begin
         if (((i >> b) & 1) == 1) r = r + (1 << (TOTAL_STEP - 1 - b));
      end
      return r;
`else
      return i;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " m_valid"},  64'(m_valid),  64'd0);
      checkOutput({tag, " m_real"},   64'(m_real),   64'd0);
      checkOutput({tag, " m_imag"},   64'(m_imag),   64'd0);
      checkOutput({tag, " m_index"},  64'(m_index),  64'd0);
      checkOutput({tag, " m_last"},   64'(m_last),   64'd0);
      checkOutput({tag, " ovf"},      64'(ovf),      64'd0);
      checkOutput({tag, " drop_cnt"}, 64'(drop_cnt), 64'd0);
   endtask

   task automatic flushModel();
      expQ.delete();
      expDrops     = 0;
      expOvf       = 0;
      framesPushed = 0;
      framesDone   = 0;
   endtask

   // pattern 0: ramp real=k imag=-k; otherwise random. nSamples < FFT_MAX leaves a partial frame.
   task automatic applyStimulus(input int pattern, input int gapPct, input int willDrop, input int nSamples);
      logic [DATA_WIDTH-1:0] re [FFT_MAX];
      logic [DATA_WIDTH-1:0] im [FFT_MAX];
      outSample_t s;
      for (int k = 0; k < FFT_MAX; k++) begin
         if (pattern == 0) begin
            re[k] = DATA_WIDTH'(k);
            im[k] = DATA_WIDTH'(-k);
         end else begin
            re[k] = DATA_WIDTH'($urandom());
            im[k] = DATA_WIDTH'($urandom());
         end
      end
      for (int k = 0; k < nSamples; k++) begin
         while (gapPct > 0 && $urandom_range(0, 99) < gapPct) begin
            @(posedge iclk); #1;
            ien = 1'b0;
         end
         @(posedge iclk); #1;
         ien   = 1'b1;
         iReal = re[k];
         iImag = im[k];
      end
      if (nSamples == FFT_MAX) begin
         if (willDrop != 0) begin
            expOvf = 1;
            if (expDrops < 255) expDrops++;
         end else begin
            for (int i = 0; i < FFT_MAX; i++) begin
               s.re   = re[srcOf(i)];
               s.im   = im[srcOf(i)];
               s.idx  = TOTAL_STEP'(i);
               s.last = (i == FFT_MAX - 1);
               expQ.push_back(s);
            end
            framesPushed++;
         end
      end
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge iclk); #1;
         ien = 1'b0;
      end
   endtask

   task automatic waitDrain(input int budget);
      int n = 0;
      while (expQ.size() > 0 && n < budget) begin
         @(posedge iclk);
         n++;
      end
      #1;
      checkOutput("drain queue", 64'(expQ.size()), 64'd0);
   endtask

   task automatic waitSlot();
      int n = 0;
      while ((framesPushed - framesDone) >= 2 && n < 2000) begin
         @(posedge iclk);
         n++;
      end
      #1;
      checkOutput("buffer slot", 64'((framesPushed - framesDone) < 2), 64'd1);
   endtask

   initial begin
      forever begin
         @(posedge iclk); #1;
         case (readyMode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            2:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = ~m_ready;
         endcase
      end
   end

   // Monitor: pops the scoreboard on each handshake and checks stalled outputs stay put.
   initial begin
      outSample_t exp;
      logic [DATA_WIDTH*2+TOTAL_STEP:0] held;
      int prevStall;
      prevStall = 0;
      held = '0;
      forever begin
         @(negedge iclk);
         if (!rstn || iclr) begin
            prevStall = 0;
            continue;
         end
         if (prevStall != 0) begin
            checkOutput("hold stable", 64'({m_valid, m_real, m_imag, m_index, m_last}), 64'({1'b1, held}));
         end
         if (m_valid && m_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("spurious m_valid", 64'(m_valid), 64'd0);
            end else begin
               exp = expQ.pop_front();
               checkOutput($sformatf("sample idx %0d", exp.idx), 64'({m_real, m_imag, m_index, m_last}), 64'(exp));
               if (exp.last) framesDone++;
            end
         end
         if (bubbleArm != 0) begin
            if (m_valid && m_ready) hsCount++;
            else if (hsCount > 0 && hsCount < bubbleTarget) bubbles++;
         end
         prevStall = (m_valid && !m_ready) ? 1 : 0;
         held = {m_real, m_imag, m_index, m_last};
      end
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      repeat (3) @(posedge iclk);
      @(negedge iclk);
      checkResetValues("reset");
      @(posedge iclk); #1;
      rstn = 1'b1;

      // Single ramp frame, latency to first output.
      readyMode = 1;
      idleCycles(2);
      applyStimulus(0, 0, 0, FFT_MAX);
      idleCycles(1);
      @(negedge iclk);
      checkOutput("latency after E valid", 64'(m_valid), 64'd0);
      @(negedge iclk);
      checkOutput("latency after E+1 valid", 64'(m_valid), 64'd1);
      checkOutput("latency after E+1 index", 64'(m_index), 64'd0);
      waitDrain(300);

      // Toggling backpressure.
      readyMode = 3;
      applyStimulus(0, 0, 0, FFT_MAX);
      idleCycles(1);
      waitDrain(400);

      // Back-to-back frames with continuous ready: no bubbles, no drops.
      readyMode    = 1;
      hsCount      = 0;
      bubbles      = 0;
      bubbleTarget = 3 * FFT_MAX;
      bubbleArm    = 1;
      applyStimulus(1, 0, 0, FFT_MAX);
      applyStimulus(1, 0, 0, FFT_MAX);
      applyStimulus(1, 0, 0, FFT_MAX);
      idleCycles(1);
      waitDrain(400);
      bubbleArm = 0;
      checkOutput("back-to-back bubbles", 64'(bubbles), 64'd0);
      checkOutput("back-to-back handshakes", 64'(hsCount), 64'(3 * FFT_MAX));
      checkOutput("back-to-back ovf", 64'(ovf), 64'(expOvf));
      checkOutput("back-to-back drop_cnt", 64'(drop_cnt), 64'(expDrops));

      // Random data, random input gaps, random ready, never more than two frames outstanding.
      readyMode = 2;
      for (int f = 0; f < 6; f++) begin
         waitSlot();
         applyStimulus(1, $urandom_range(0, 40), 0, FFT_MAX);
         idleCycles(1);
      end
      waitDrain(2000);
      checkOutput("random drop_cnt", 64'(drop_cnt), 64'(expDrops));

      // Overflow: two frames buffered, further frames dropped; counter saturates.
      readyMode = 0;
      idleCycles(2);
      applyStimulus(1, 0, 0, FFT_MAX);
      applyStimulus(1, 0, 0, FFT_MAX);
      applyStimulus(1, 0, 1, FFT_MAX);
      idleCycles(2);
      checkOutput("overflow ovf", 64'(ovf), 64'(expOvf));
      checkOutput("overflow drop_cnt", 64'(drop_cnt), 64'(expDrops));
      for (int f = 0; f < 256; f++) begin
         applyStimulus(1, 0, 1, FFT_MAX);
      end
      idleCycles(2);
      checkOutput("saturated drop_cnt", 64'(drop_cnt), 64'(expDrops));
      checkOutput("saturated ovf", 64'(ovf), 64'(expOvf));
      readyMode = 1;
      waitDrain(400);

      // Synchronous clear with a buffered frame and a partial frame in flight.
      readyMode = 0;
      idleCycles(2);
      applyStimulus(1, 0, 0, FFT_MAX);
      applyStimulus(1, 0, 0, 30);
      @(posedge iclk); #1;
      ien  = 1'b0;
      iclr = 1'b1;
      @(posedge iclk); #1;
      iclr = 1'b0;
      flushModel();
      @(negedge iclk);
      checkResetValues("iclr");
      readyMode = 1;
      applyStimulus(0, 10, 0, FFT_MAX);
      idleCycles(1);
      waitDrain(400);
      checkOutput("after iclr drop_cnt", 64'(drop_cnt), 64'd0);

      // Asynchronous reset at input sample 20 with a buffered frame waiting.
      readyMode = 0;
      idleCycles(2);
      applyStimulus(1, 0, 0, FFT_MAX);
      applyStimulus(1, 0, 0, 20);
      @(posedge iclk); #1;
      rstn = 1'b0;
      ien  = 1'b0;
      flushModel();
      @(negedge iclk);
      checkResetValues("reset mid-frame");
      @(posedge iclk); #1;
      rstn = 1'b1;
      readyMode = 1;
      applyStimulus(0, 0, 0, FFT_MAX);
      idleCycles(1);
      waitDrain(400);
      checkOutput("after reset drop_cnt", 64'(drop_cnt), 64'd0);
      checkOutput("after reset ovf", 64'(ovf), 64'd0);

      idleCycles(10);
      checkOutput("final queue empty", 64'(expQ.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
